mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max BUSY cycles without mem_ack before a fault.
REQ-002 SHALL have port clk  in  1  clock; all state updates on the falling edge, matching the pipeline registers.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port MemRead_in  in  1  load request from the EX/MEM register.
REQ-005 SHALL have port MemWrite_in  in  1  store request from the EX/MEM register.
REQ-006 SHALL have port addr_in  in  32  byte address (EX/MEM alu_out).
REQ-007 SHALL have port wdata_in  in  32  store data (EX/MEM RD3_out).
REQ-008 SHALL have port mem_ack  in  1  data-memory completion strobe.
REQ-009 SHALL have port mem_rdata  in  32  data-memory read data, valid with mem_ack.
REQ-010 SHALL have port mem_req  out  1  memory request, registered.
REQ-011 SHALL have port mem_we  out  1  1 = write, registered.
REQ-012 SHALL have port mem_addr  out  32  latched address.
REQ-013 SHALL have port mem_wdata  out  32  latched store data.
REQ-014 SHALL have port stall  out  1  freeze IF/ID, ID/EX, EX/MEM registers.
REQ-015 SHALL have port rdata_out  out  32  load result to MEM/WB.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port fault  out  1  sticky error flag.
REQ-018 SHALL have port fault_code  out  2  01 misaligned, 10 timeout, 11 read+write conflict, 00 none.

Function
REQ-019 SHALL implement states IDLE, BUSY, DONE, FAULT.
REQ-020 "Access" = MemRead_in XOR MemWrite_in; "legal" = access and addr_in[1:0]==00.
REQ-021 IDLE, no access and not both asserted: stay IDLE, stall=0, mem_req=0.
REQ-022 IDLE, legal access: stall=1 combinationally in the same cycle; at the next edge latch addr_in, wdata_in, mem_we=MemWrite_in, set mem_req=1, wait counter=0, go BUSY.
REQ-023 BUSY: stall=1, mem_req held 1; addr/data/we SHALL not change.
REQ-024 BUSY, edge with mem_ack=1: mem_req=0; if read, rdata_out=mem_rdata; go DONE.
REQ-025 BUSY, edge with mem_ack=0: counter+1; counter reaching TIMEOUT SHALL go FAULT with fault_code=10.
REQ-026 DONE: done=1, stall=0 for exactly one cycle; unconditionally return to IDLE so the pipeline advances and the same access is never reissued.
REQ-027 rdata_out SHALL hold its value until the next completed read; writes SHALL not modify it.
REQ-028 IDLE with misaligned access: go FAULT, fault_code=01, no mem_req issued.
REQ-029 IDLE with MemRead_in and MemWrite_in both 1: go FAULT, fault_code=11, no mem_req issued; this check takes priority over alignment.
REQ-030 Entering FAULT SHALL set fault=1; in FAULT stall=1, mem_req=0, done=0; remain until reset.
REQ-031 mem_ack outside BUSY SHALL be ignored.
REQ-032 Counter SHALL be wide enough for TIMEOUT and SHALL not wrap.
REQ-033 Minimum access latency: 3 edges from request seen in IDLE to stall release (IDLE->BUSY, BUSY->DONE with ack, DONE->IDLE).

Reset
REQ-034 rst=1 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, done=0, fault=0, fault_code=00, counter=0, regardless of clk.
REQ-035 rst during BUSY SHALL abort the access with no done pulse; stall SHALL follow IDLE rules from then on.

Verification
REQ-036 Read addr 0x100, ack on 3rd BUSY cycle, rdata 0xDEADBEEF -> mem_req high 3 cycles, rdata_out=0xDEADBEEF, one done pulse, stall low after DONE.
REQ-037 Write addr 0x104 data 0x12345678, ack on 1st BUSY cycle -> mem_we=1, mem_wdata=0x12345678, rdata_out unchanged.
REQ-038 Read addr 0x102 -> fault=1, fault_code=01, mem_req never asserted, stall stuck 1.
REQ-039 Read with TIMEOUT=4, no ack -> FAULT after 4 BUSY cycles, fault_code=10, mem_req drops.
REQ-040 Both MemRead_in and MemWrite_in =1 at addr 0x101 -> fault_code=11.
REQ-041 rst pulsed mid-BUSY, then two back-to-back legal reads -> all outputs zero on reset, no done pulse; each subsequent read yields exactly one done and no duplicate mem_req.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: issues one request per load/store,
// stalls the pipeline until the memory acknowledges, and traps misaligned, conflicting or hung accesses.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;

    state_t            state;
    logic [CntW-1:0]   wait_cnt;
    logic              access;
    logic              conflict;
    logic              legal;

    assign access   = MemRead_in ^ MemWrite_in;
    assign conflict = MemRead_in & MemWrite_in;
    assign legal    = access && (addr_in[1:0] == 2'b00);

    // State advances on the falling edge, in step with the pipeline registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            rdata_out  <= 32'h0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (conflict) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b11;
                    end else if (legal) begin
                        mem_addr  <= addr_in;
                        mem_wdata <= wdata_in;
                        mem_we    <= MemWrite_in;
                        mem_req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= BUSY;
                    end else if (access) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata_out <= mem_rdata;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == CntW'(TIMEOUT - 1)) begin
                        // Saturate at TIMEOUT; the counter never wraps.
                        wait_cnt   <= CntW'(TIMEOUT);
                        mem_req    <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        state      <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    // Stall is raised combinationally so the requesting instruction freezes in its own cycle.
    always_comb begin
        stall = 1'b1;
        case (state)
            IDLE:    stall = MemRead_in | MemWrite_in;
            BUSY:    stall = 1'b1;
            DONE:    stall = 1'b0;
            FAULT:   stall = 1'b1;
            default: stall = 1'b1;
        endcase
    end

endmodule
